my_serial_logic: RTL and testbench
==================================

// Module: my_serial_logic
// PURPOSE
//  Multi-cycle bit-serial logic unit for the ALU datapath: AND/OR/XOR/NOR of two 32-bit operands.
//  Processes one bit per cycle, LSB first, and is the area-minimal alternative to the parallel gate-level logic slices.
//  Sits beside the ALU operation mux. Valid/ready handshake on the request side and on the result side.
// PARAMETERS
//  WIDTH    32  operand/result width; must be >= 2
//  CNT_W    6   bit-counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      synchronous, active-high reset
//  in_valid     in   1      request valid
//  in_ready     out  1      unit can accept a request (high only in IDLE)
//  first        in   WIDTH  operand A
//  second       in   WIDTH  operand B
//  op           in   2      00 AND, 01 OR, 10 XOR, 11 NOR
//  out_valid    out  1      result valid (DONE state)
//  out_ready    in   1      consumer accepts result
//  result       out  WIDTH  logic result, held stable while out_valid=1
//  zero         out  1      result == 0, valid with out_valid
// BEHAVIOUR
//  - Reset: state=IDLE, in_ready=1, out_valid=0, result=0, zero=0, counter=0.
//  - FSM: IDLE -(in_valid&in_ready)-> BUSY -(count==WIDTH-1)-> DONE -(out_ready)-> IDLE.
//  - Accept in IDLE: latch first, second and op into shift regs A, B and op reg. Clear result and counter.
//  - BUSY, each cycle: bit = f(op, A[0], B[0]). Shift result right and insert bit at MSB. Shift A and B right. count++.
//  - After WIDTH BUSY cycles, result[i] = f(op, first[i], second[i]) for all i.
//  - Latency: acceptance edge to out_valid=1 is WIDTH+1 cycles (33 by default). Single request in flight.
//  - zero is computed as a running OR of the produced bits, inverted at DONE. No separate reduction tree.
//  - DONE: out_valid=1, result/zero frozen until the out_ready handshake.
//  - A DONE->IDLE transition and a new accept never occur in the same cycle: in_ready=0 in DONE.
//  - Input changes while BUSY/DONE are ignored. in_valid while not ready is dropped only if deasserted.
//  - reset mid-BUSY or mid-DONE: abort, return to the reset values on the next edge, no partial result exposed.
//  - Illegal FSM encoding: next state = IDLE.
// CONFIGURATION
//  MY_SERIAL_LOGIC_DUAL_BIT_EN:
//  - Defined: 2 bits per cycle, BUSY lasts WIDTH/2 cycles. Latency is WIDTH/2+1 (17). WIDTH must be even.
//  - Not defined: 1 bit per cycle as above. Port list identical in both builds.
// STRUCTURE
//  - Shared package alu_pkg: op encodings (OP_AND..OP_NOR), FSM state enum (S_IDLE, S_BUSY, S_DONE).
//  - Sub-module my_logic_bit: combinational single-bit f(op,a,b). Instanced once, or twice under the _EN macro.
//  - Top holds the FSM, counter, shift registers and zero accumulator.
// TESTING
//  1. reset held 3 cycles, then released -> in_ready=1, out_valid=0, result=0.
//  2. AND: first=32'hF0F0_1234, second=32'hFFFF_0F0F -> after 33 cycles out_valid=1, result=32'hF0F0_0204, zero=0.
//  3. XOR: first=second=32'hDEAD_BEEF -> result=0, zero=1. NOR with both operands 0 -> result=32'hFFFF_FFFF.
//  4. out_ready held low 10 cycles in DONE -> result stable, in_ready=0, a new in_valid is not accepted.
//     Then out_ready=1 -> IDLE next cycle.
//  5. reset asserted at BUSY count 15 -> next cycle IDLE, out_valid=0. A fresh OR request completes correctly.
//  6. Back-to-back: 1000 random ops checked against a reference model. Under the _EN macro, latency must be 17.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: logic-op encodings and the serial-unit FSM states.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/my_logic_bit.sv
// Single-bit combinational logic function y = f(op, a, b).
module my_logic_bit
    import alu_pkg::*;
(
    input  op_e  i_op,
    input  logic i_a,
    input  logic i_b,
    output logic o_y_c
);

    always_comb begin
        o_y_c = 1'b0;
        case (i_op)
            OP_AND:  o_y_c = i_a & i_b;
            OP_OR:   o_y_c = i_a | i_b;
            OP_XOR:  o_y_c = i_a ^ i_b;
            OP_NOR:  o_y_c = ~(i_a | i_b);
            default: o_y_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/my_serial_logic.sv
// Bit-serial AND/OR/XOR/NOR unit, LSB first, valid/ready on both sides.
// Define MY_SERIAL_LOGIC_DUAL_BIT_EN to process two bits per cycle (WIDTH must be even).
module my_serial_logic
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] first,
    input  logic [WIDTH-1:0] second,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

`ifdef MY_SERIAL_LOGIC_DUAL_BIT_EN
    localparam int unsigned BITS_PER_CYC = 2;
`else
    localparam int unsigned BITS_PER_CYC = 1;
`endif
    localparam int unsigned LAST_CNT = WIDTH / BITS_PER_CYC - 1;

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [WIDTH-1:0]        r_a;
    logic [WIDTH-1:0]        r_b;
    logic [WIDTH-1:0]        r_result;
    op_e                     r_op;
    logic [CNT_W-1:0]        r_count;
    logic                    r_any;
    logic                    r_zero;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic [BITS_PER_CYC-1:0] w_bits;
    logic                    w_accept;
    logic                    w_last;

    assign w_accept = in_valid && (r_state == S_IDLE);
    assign w_last   = (r_count == CNT_W'(LAST_CNT));

    // One logic slice per bit retired each cycle
    for (genvar g = 0; g < BITS_PER_CYC; g++) begin : g_bit
        my_logic_bit u_bit (
            .i_op  (r_op),
            .i_a   (r_a[g]),
            .i_b   (r_b[g]),
            .o_y_c (w_bits[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = S_IDLE;
        case (r_state)
            S_IDLE:  w_state_nxt = w_accept  ? S_BUSY : S_IDLE;
            S_BUSY:  w_state_nxt = w_last    ? S_DONE : S_BUSY;
            S_DONE:  w_state_nxt = out_ready ? S_IDLE : S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath; handshake flags are registered from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_op        <= OP_AND;
            r_count     <= '0;
            r_any       <= 1'b0;
            r_zero      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_DONE);
            if (w_accept) begin
                r_a      <= first;
                r_b      <= second;
                r_op     <= op_e'(op);
                r_result <= '0;
                r_count  <= '0;
                r_any    <= 1'b0;
                r_zero   <= 1'b0;
            end else if (r_state == S_BUSY) begin
                r_a      <= r_a >> BITS_PER_CYC;
                r_b      <= r_b >> BITS_PER_CYC;
                r_result <= {w_bits, r_result[WIDTH-1:BITS_PER_CYC]};
                r_count  <= r_count + CNT_W'(1);
                r_any    <= r_any | (|w_bits);
                if (w_last) begin
                    r_zero <= ~(r_any | (|w_bits));
                end
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;

endmodule

// File: tb/tb_my_serial_logic.sv
// Directed and random self-checking bench for my_serial_logic.
module tb_my_serial_logic;

    localparam int unsigned WIDTH = 32;
`ifdef MY_SERIAL_LOGIC_DUAL_BIT_EN
    localparam int unsigned EXP_LAT = WIDTH / 2 + 1;
`else
    localparam int unsigned EXP_LAT = WIDTH + 1;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] first;
    logic [WIDTH-1:0] second;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;

    int n_checks = 0;
    int n_errors = 0;

    my_serial_logic #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .first     (first),
        .second    (second),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_f(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        case (o)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    // Present a request, then wait (bounded) for out_valid; lat counts edges from the accept edge
    task automatic start_req(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                             output int lat);
        op       = o;
        first    = a;
        second   = b;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        first    = ~a;
        second   = b ^ 32'h5555_5555;
        op       = ~o;
        lat      = 1;
        while (!out_valid && lat < 200) begin
            tick;
            lat++;
        end
    endtask

    task automatic finish_req;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [31:0] held;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  o;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        first     = '0;
        second    = '0;
        op        = 2'b00;

        // Reset held three cycles
        repeat (3) tick;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        reset = 1'b0;
        tick;
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_result", result, 32'h0);
        chk("idle_zero", 32'(zero), 32'd0);

        // AND
        start_req(2'b00, 32'hF0F0_1234, 32'hFFFF_0F0F, lat);
        chk("and_lat", 32'(lat), 32'(EXP_LAT));
        chk("and_result", result, 32'hF0F0_0204);
        chk("and_zero", 32'(zero), 32'd0);
        chk("and_in_ready", 32'(in_ready), 32'd0);
        finish_req;
        chk("and_ret_idle", 32'(in_ready), 32'd1);
        chk("and_ret_ov", 32'(out_valid), 32'd0);

        // XOR of equal operands gives zero
        start_req(2'b10, 32'hDEAD_BEEF, 32'hDEAD_BEEF, lat);
        chk("xor_lat", 32'(lat), 32'(EXP_LAT));
        chk("xor_result", result, 32'h0);
        chk("xor_zero", 32'(zero), 32'd1);
        finish_req;

        // NOR of zeros gives all ones
        start_req(2'b11, 32'h0, 32'h0, lat);
        chk("nor_result", result, 32'hFFFF_FFFF);
        chk("nor_zero", 32'(zero), 32'd0);
        finish_req;

        // Back-pressure in DONE with a competing request
        start_req(2'b01, 32'h1200_0034, 32'h0056_7800, lat);
        chk("bp_result0", result, 32'h1256_7834);
        held = result;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            first    = 32'hFFFF_FFFF;
            second   = 32'h0;
            op       = 2'b00;
            tick;
            chk("bp_stable", result, held);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk("bp_ret_idle", 32'(in_ready), 32'd1);
        chk("bp_ret_ov", 32'(out_valid), 32'd0);

        // Reset at BUSY count 15
        op       = 2'b00;
        first    = 32'hFFFF_FFFF;
        second   = 32'hFFFF_FFFF;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (15) tick;
        chk("mid_busy_ov", 32'(out_valid), 32'd0);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_result", result, 32'h0);
        chk("abort_zero", 32'(zero), 32'd0);
        start_req(2'b01, 32'hA5A5_0000, 32'h0000_5A5A, lat);
        chk("post_abort_lat", 32'(lat), 32'(EXP_LAT));
        chk("post_abort_or", result, 32'hA5A5_5A5A);
        finish_req;

        // Back-to-back random requests against the reference model
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? a : 32'($urandom);
            o = 2'($urandom_range(0, 3));
            start_req(o, a, b, lat);
            chk("rand_lat", 32'(lat), 32'(EXP_LAT));
            chk("rand_result", result, ref_f(o, a, b));
            chk("rand_zero", 32'(zero), 32'(ref_f(o, a, b) == 32'h0));
            finish_req;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
